// File: rtl/scalar_operand_loader.sv
// Gathers lane_depth_p bus beats into a sign-extended operand tensor; double-banked when SCALAR_LOADER_DOUBLE_BUF_EN is defined.
// Latency: valid 1 cycle after the last beat; backpressure: load_ready_o drops while a finished tensor cannot be handed over.
module scalar_operand_loader #(
    parameter int in_width_p   = 32,
    parameter int out_width_p  = 32,
    parameter int lane_depth_p = 4,
    parameter int bus_width_p  = 64,
    parameter int num_lanes_p  = bus_width_p / in_width_p,
    parameter int cnt_w_p      = $clog2(lane_depth_p + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          clear_i,
    input  logic [bus_width_p-1:0]        read_bus_i,
    input  logic                          load_valid_i,
    input  logic                          load_enable_i,
    output logic                          load_ready_o,
    input  logic                          consume_i,
    output logic                          values_valid_o,
    output logic [cnt_w_p-1:0]            beat_cnt_o,
    output logic                          drop_err_o,
    output logic signed [out_width_p-1:0] scalar_values_o [0:num_lanes_p*lane_depth_p-1]
);

    localparam int                 elems_lp     = num_lanes_p * lane_depth_p;
    localparam logic [cnt_w_p-1:0] last_beat_lp = cnt_w_p'(lane_depth_p - 1);
    localparam logic [cnt_w_p-1:0] full_cnt_lp  = cnt_w_p'(lane_depth_p);

    if ((bus_width_p % in_width_p) != 0) begin : g_bus_width_check
        $error("scalar_operand_loader: bus_width_p must be a multiple of in_width_p");
    end
    if (out_width_p < in_width_p) begin : g_out_width_check
        $error("scalar_operand_loader: out_width_p must be >= in_width_p");
    end

    logic signed [out_width_p-1:0] beat_ext [0:num_lanes_p-1];
    logic signed [out_width_p-1:0] fill_d   [0:elems_lp-1];
    logic                          accept;
    logic                          offer_blocked;
    logic                          last_beat;

    assign accept        = load_valid_i & load_enable_i & load_ready_o;
    assign offer_blocked = load_valid_i & load_enable_i & ~load_ready_o;
    assign last_beat     = accept & (beat_cnt_o == last_beat_lp);

    always_comb begin
        for (int l = 0; l < num_lanes_p; l++) begin
            beat_ext[l] = out_width_p'(signed'(read_bus_i[l*in_width_p +: in_width_p]));
        end
    end

`ifdef SCALAR_LOADER_DOUBLE_BUF_EN
    logic signed [out_width_p-1:0] fill_q [0:elems_lp-1];
    logic                          pending_q;
    logic                          xfer;

    // Handover happens either when a parked tensor is released or when the
    // last beat arrives while the output bank is free on this same edge.
    assign xfer         = (pending_q & consume_i) | (last_beat & (~values_valid_o | consume_i));
    assign load_ready_o = ~pending_q;

    always_comb begin
        fill_d = fill_q;
        if (accept) begin
            for (int k = 0; k < lane_depth_p; k++) begin
                for (int l = 0; l < num_lanes_p; l++) begin
                    if (int'(beat_cnt_o) == k) fill_d[k*num_lanes_p + l] = beat_ext[l];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < elems_lp; i++) begin
                fill_q[i]          <= '0;
                scalar_values_o[i] <= '0;
            end
            pending_q      <= 1'b0;
            values_valid_o <= 1'b0;
            beat_cnt_o     <= '0;
            drop_err_o     <= 1'b0;
        end else begin
            if (offer_blocked) drop_err_o <= 1'b1;
            if (clear_i) begin
                pending_q      <= 1'b0;
                values_valid_o <= 1'b0;
                beat_cnt_o     <= '0;
            end else begin
                if (accept) fill_q <= fill_d;
                if (xfer) begin
                    scalar_values_o <= fill_d;
                    values_valid_o  <= 1'b1;
                    pending_q       <= 1'b0;
                    beat_cnt_o      <= '0;
                end else begin
                    if (last_beat) begin
                        pending_q  <= 1'b1;
                        beat_cnt_o <= full_cnt_lp;
                    end else if (accept) begin
                        beat_cnt_o <= beat_cnt_o + 1'b1;
                    end
                    if (consume_i) values_valid_o <= 1'b0;
                end
            end
        end
    end
`else
    // Single bank: beats land straight in the output array, so partial fills
    // are visible while values_valid_o is low.
    assign load_ready_o = ~values_valid_o;

    always_comb begin
        fill_d = scalar_values_o;
        if (accept) begin
            for (int k = 0; k < lane_depth_p; k++) begin
                for (int l = 0; l < num_lanes_p; l++) begin
                    if (int'(beat_cnt_o) == k) fill_d[k*num_lanes_p + l] = beat_ext[l];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < elems_lp; i++) begin
                scalar_values_o[i] <= '0;
            end
            values_valid_o <= 1'b0;
            beat_cnt_o     <= '0;
            drop_err_o     <= 1'b0;
        end else begin
            if (offer_blocked) drop_err_o <= 1'b1;
            if (clear_i) begin
                values_valid_o <= 1'b0;
                beat_cnt_o     <= '0;
            end else begin
                if (accept) scalar_values_o <= fill_d;
                if (last_beat) begin
                    values_valid_o <= 1'b1;
                    beat_cnt_o     <= full_cnt_lp;
                end else if (accept) begin
                    beat_cnt_o <= beat_cnt_o + 1'b1;
                end
                if (consume_i && values_valid_o) begin
                    values_valid_o <= 1'b0;
                    beat_cnt_o     <= '0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_scalar_operand_loader.sv
// Directed bench for scalar_operand_loader; adapts expectations to SCALAR_LOADER_DOUBLE_BUF_EN.
module tb_scalar_operand_loader;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               clear;
    logic [63:0]        bus;
    logic               lv, le, consume;
    logic               rdy, vvld, derr;
    logic [2:0]         cnt;
    logic signed [31:0] vals [0:7];

    logic [15:0]        bus8;
    logic               lv8, le8, consume8;
    logic               rdy8, vvld8, derr8;
    logic [2:0]         cnt8;
    logic signed [31:0] vals8 [0:7];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scalar_operand_loader dut (
        .clk_i(clk), .reset_ni(reset_n), .clear_i(clear), .read_bus_i(bus),
        .load_valid_i(lv), .load_enable_i(le), .load_ready_o(rdy), .consume_i(consume),
        .values_valid_o(vvld), .beat_cnt_o(cnt), .drop_err_o(derr), .scalar_values_o(vals)
    );

    scalar_operand_loader #(.in_width_p(8), .out_width_p(32), .lane_depth_p(4), .bus_width_p(16)) dut8 (
        .clk_i(clk), .reset_ni(reset_n), .clear_i(clear), .read_bus_i(bus8),
        .load_valid_i(lv8), .load_enable_i(le8), .load_ready_o(rdy8), .consume_i(consume8),
        .values_valid_o(vvld8), .beat_cnt_o(cnt8), .drop_err_o(derr8), .scalar_values_o(vals8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat holds element base+2k in lane 0 and base+2k+1 in lane 1.
    task automatic send_beat(input logic [31:0] lo, input logic [31:0] hi);
        bus = {hi, lo};
        lv = 1'b1;
        le = 1'b1;
        tick();
        lv = 1'b0;
        le = 1'b0;
    endtask

    task automatic send_tensor(input logic [31:0] base);
        for (int k = 0; k < 4; k++) send_beat(base + 2*k, base + 2*k + 1);
    endtask

    task automatic pulse_consume();
        consume = 1'b1;
        tick();
        consume = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy); end
        checks++;
        if (vvld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vvld); end
        checks++;
        if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        checks++;
        if (derr !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %b expected 0", derr); end
        checks++;
        if (vals[0] !== 32'd0) begin errors++; $display("FAIL reset_values: got %h expected 0", vals[0]); end
        checks++;
        #10 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        for (int k = 0; k < 3; k++) send_beat(32'(2*k + 1), 32'(2*k + 2));
        if (vvld !== 1'b0) begin errors++; $display("FAIL load_valid_early: got %b expected 0", vvld); end
        checks++;
        if (cnt !== 3'd3) begin errors++; $display("FAIL load_cnt_3: got %0d expected 3", cnt); end
        checks++;
        send_beat(32'd7, 32'd8);
        if (vvld !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", vvld); end
        checks++;
        for (int i = 0; i < 8; i++) begin
            if (vals[i] !== 32'(i + 1)) begin
                errors++; $display("FAIL load_value[%0d]: got %h expected %h", i, vals[i], i + 1);
            end
            checks++;
        end
`ifdef SCALAR_LOADER_DOUBLE_BUF_EN
        if (cnt !== 3'd0) begin errors++; $display("FAIL load_cnt_done: got %0d expected 0", cnt); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL load_ready_done: got %b expected 1", rdy); end
        checks++;
`else
        if (cnt !== 3'd4) begin errors++; $display("FAIL load_cnt_done: got %0d expected 4", cnt); end
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL load_ready_done: got %b expected 0", rdy); end
        checks++;
`endif
        pulse_consume();
        if (vvld !== 1'b0) begin errors++; $display("FAIL consume_valid: got %b expected 0", vvld); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL consume_ready: got %b expected 1", rdy); end
        checks++;
        if (cnt !== 3'd0) begin errors++; $display("FAIL consume_cnt: got %0d expected 0", cnt); end
        checks++;
        if (vals[3] !== 32'd4) begin errors++; $display("FAIL consume_data_hold: got %h expected 4", vals[3]); end
        checks++;
    endtask

    task automatic test_sign_ext();
        logic [15:0] beats [0:3];
        beats[0] = 16'h7F80;
        beats[1] = 16'h0102;
        beats[2] = 16'h0304;
        beats[3] = 16'h01FE;
        for (int k = 0; k < 4; k++) begin
            bus8 = beats[k];
            lv8 = 1'b1;
            le8 = 1'b1;
            tick();
        end
        lv8 = 1'b0;
        le8 = 1'b0;
        if (vvld8 !== 1'b1) begin errors++; $display("FAIL sext_valid: got %b expected 1", vvld8); end
        checks++;
        if (vals8[0] !== 32'hFFFFFF80) begin errors++; $display("FAIL sext_neg: got %h expected ffffff80", vals8[0]); end
        checks++;
        if (vals8[1] !== 32'h0000007F) begin errors++; $display("FAIL sext_pos: got %h expected 0000007f", vals8[1]); end
        checks++;
        if (vals8[6] !== 32'hFFFFFFFE) begin errors++; $display("FAIL sext_last_lo: got %h expected fffffffe", vals8[6]); end
        checks++;
        if (vals8[7] !== 32'h00000001) begin errors++; $display("FAIL sext_last_hi: got %h expected 00000001", vals8[7]); end
        checks++;
        consume8 = 1'b1;
        tick();
        consume8 = 1'b0;
    endtask

    task automatic test_clear();
        send_beat(32'hAA, 32'hAB);
        send_beat(32'hAC, 32'hAD);
        bus = {32'hEE, 32'hEF};
        lv = 1'b1; le = 1'b1; consume = 1'b1; clear = 1'b1;
        tick();
        lv = 1'b0; le = 1'b0; consume = 1'b0; clear = 1'b0;
        if (cnt !== 3'd0) begin errors++; $display("FAIL clear_cnt: got %0d expected 0", cnt); end
        checks++;
        if (vvld !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", vvld); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b expected 1", rdy); end
        checks++;
        send_tensor(32'h50);
        if (vals[0] !== 32'h50) begin errors++; $display("FAIL clear_refill_first: got %h expected 50", vals[0]); end
        checks++;
        if (vals[7] !== 32'h57) begin errors++; $display("FAIL clear_refill_last: got %h expected 57", vals[7]); end
        checks++;
        pulse_consume();
    endtask

`ifdef SCALAR_LOADER_DOUBLE_BUF_EN
    task automatic test_backpressure();
        send_tensor(32'h100);
        send_tensor(32'h200);
        if (rdy !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", rdy); end
        checks++;
        if (cnt !== 3'd4) begin errors++; $display("FAIL bp_cnt: got %0d expected 4", cnt); end
        checks++;
        if (vals[0] !== 32'h100) begin errors++; $display("FAIL bp_holds_a: got %h expected 100", vals[0]); end
        checks++;
        send_beat(32'h999, 32'h998);
        if (derr !== 1'b1) begin errors++; $display("FAIL bp_drop_err: got %b expected 1", derr); end
        checks++;
        pulse_consume();
        if (vvld !== 1'b1) begin errors++; $display("FAIL bp_valid_stays: got %b expected 1", vvld); end
        checks++;
        if (vals[0] !== 32'h200) begin errors++; $display("FAIL bp_shows_b_first: got %h expected 200", vals[0]); end
        checks++;
        if (vals[7] !== 32'h207) begin errors++; $display("FAIL bp_shows_b_last: got %h expected 207", vals[7]); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", rdy); end
        checks++;
        if (cnt !== 3'd0) begin errors++; $display("FAIL bp_cnt_back: got %0d expected 0", cnt); end
        checks++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) send_beat(32'h300 + 2*k, 32'h301 + 2*k);
        bus = {32'h307, 32'h306};
        lv = 1'b1; le = 1'b1; consume = 1'b1;
        tick();
        lv = 1'b0; le = 1'b0; consume = 1'b0;
        if (vvld !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", vvld); end
        checks++;
        if (vals[0] !== 32'h300) begin errors++; $display("FAIL b2b_first: got %h expected 300", vals[0]); end
        checks++;
        if (vals[7] !== 32'h307) begin errors++; $display("FAIL b2b_last: got %h expected 307", vals[7]); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_no_pending: got %b expected 1", rdy); end
        checks++;
        pulse_consume();
        if (vvld !== 1'b0) begin errors++; $display("FAIL b2b_consume: got %b expected 0", vvld); end
        checks++;
    endtask
`else
    task automatic test_backpressure();
        send_tensor(32'h100);
        if (vvld !== 1'b1) begin errors++; $display("FAIL sb_valid: got %b expected 1", vvld); end
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL sb_ready: got %b expected 0", rdy); end
        checks++;
        send_beat(32'h999, 32'h998);
        if (derr !== 1'b1) begin errors++; $display("FAIL sb_drop_err: got %b expected 1", derr); end
        checks++;
        if (vals[0] !== 32'h100) begin errors++; $display("FAIL sb_no_write: got %h expected 100", vals[0]); end
        checks++;
        pulse_consume();
        if (vvld !== 1'b0) begin errors++; $display("FAIL sb_consume_valid: got %b expected 0", vvld); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL sb_consume_ready: got %b expected 1", rdy); end
        checks++;
        if (cnt !== 3'd0) begin errors++; $display("FAIL sb_consume_cnt: got %0d expected 0", cnt); end
        checks++;
    endtask
`endif

    task automatic test_reset_mid_fill();
        send_beat(32'h11, 32'h12);
        send_beat(32'h13, 32'h14);
        #3 reset_n = 1'b0;
        #1;
        if (cnt !== 3'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", cnt); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", rdy); end
        checks++;
        if (derr !== 1'b0) begin errors++; $display("FAIL rst_mid_drop_err: got %b expected 0", derr); end
        checks++;
        if (vals[0] !== 32'd0) begin errors++; $display("FAIL rst_mid_values: got %h expected 0", vals[0]); end
        checks++;
        #2 reset_n = 1'b1;
        tick();
        send_tensor(32'h40);
        if (vvld !== 1'b1) begin errors++; $display("FAIL rst_refill_valid: got %b expected 1", vvld); end
        checks++;
        if (vals[0] !== 32'h40) begin errors++; $display("FAIL rst_refill_first: got %h expected 40", vals[0]); end
        checks++;
        if (vals[5] !== 32'h45) begin errors++; $display("FAIL rst_refill_mid: got %h expected 45", vals[5]); end
        checks++;
    endtask

    initial begin
        reset_n = 1'b0;
        clear = 1'b0;
        bus = '0; lv = 1'b0; le = 1'b0; consume = 1'b0;
        bus8 = '0; lv8 = 1'b0; le8 = 1'b0; consume8 = 1'b0;
        test_reset();
        test_load();
        test_sign_ext();
        test_clear();
        test_backpressure();
`ifdef SCALAR_LOADER_DOUBLE_BUF_EN
        test_back_to_back();
`endif
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
